// File: rtl/pipeline_stage_register.sv
// Parametrised inter-stage pipeline register: DEPTH back-to-back stages with
// per-stage valid and flush, a global stall, and saturating stall/flush
// counters for the debug/perf path.
module pipeline_stage_register #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      DEPTH       = 1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0,
    parameter int unsigned      CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [DEPTH-1:0] flush,
    input  logic [WIDTH-1:0] d_in,
    input  logic             v_in,
    output logic [WIDTH-1:0] d_out,
    output logic             v_out,
    output logic [2:0]       occupancy,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Reject unsupported chain depths at elaboration time.
    if (DEPTH == 0 || DEPTH > 4) begin : g_depth_check
        $error("pipeline_stage_register: DEPTH must be in 1..4");
    end

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d;

    // Next stage contents: advance unless stalled, then flush overrides per stage.
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            data_d[i] = data_q[i];
        end
        valid_d = valid_q;
        if (!stall) begin
            data_d[0]  = d_in;
            valid_d[0] = v_in;
            for (int i = 1; i < int'(DEPTH); i++) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush[i]) begin
                data_d[i]  = CLEAR_VALUE;
                valid_d[i] = 1'b0;
            end
        end
    end

    // Saturating perf counters; they stop at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (|flush && flush_cnt_q != CNT_MAX) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // Stage and counter registers; reset drops all in-flight data immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= CLEAR_VALUE;
            end
            valid_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= data_d[i];
            end
            valid_q     <= valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Number of stages currently holding valid payload.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occupancy = occupancy + 3'(valid_q[i]);
        end
    end

    assign d_out        = data_q[DEPTH-1];
    assign v_out        = valid_q[DEPTH-1];
    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Scoreboard bench for pipeline_stage_register: a stage-array reference model
// predicts outputs after every edge; a monitor compares them independently.
module tb_pipeline_stage_register;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 3;
    localparam int unsigned CNT_W = 4;
    localparam logic [WIDTH-1:0] CLR = 32'hC1EA_55AA;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic             stall;
    logic [DEPTH-1:0] flush;
    logic [WIDTH-1:0] d_in;
    logic             v_in;
    logic [WIDTH-1:0] d_out;
    logic             v_out;
    logic [2:0]       occupancy;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    pipeline_stage_register #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .CLEAR_VALUE(CLR), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .d_in(d_in), .v_in(v_in), .d_out(d_out), .v_out(v_out),
        .occupancy(occupancy), .stall_cycles(stall_cycles),
        .flush_events(flush_events)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        bit               v;
    } stage_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        bit               v;
        int               occ;
        int               sc;
        int               fc;
    } exp_t;

    stage_t m [DEPTH];
    int     m_sc;
    int     m_fc;
    exp_t   exp_q [$];
    int     n_checks;
    int     n_fail;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(DEPTH); i++) begin
            m[i].d = CLR;
            m[i].v = 1'b0;
        end
        m_sc = 0;
        m_fc = 0;
    endfunction

    function automatic exp_t model_outputs();
        exp_t e;
        e.d   = m[DEPTH-1].d;
        e.v   = m[DEPTH-1].v;
        e.occ = 0;
        for (int i = 0; i < int'(DEPTH); i++) e.occ += int'(m[i].v);
        e.sc  = m_sc;
        e.fc  = m_fc;
        return e;
    endfunction

    // One clock cycle: apply inputs at the falling edge, predict, wait for the rising edge.
    task automatic drive(input bit rst_lvl, input bit st, input logic [DEPTH-1:0] fl,
                         input logic [WIDTH-1:0] d, input bit v);
        stage_t old [DEPTH];
        @(negedge clk);
        reset = rst_lvl;
        stall = st;
        flush = fl;
        d_in  = d;
        v_in  = v;
        if (!rst_lvl) begin
            model_reset();
        end else begin
            old = m;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (fl[i]) begin
                    m[i].d = CLR;
                    m[i].v = 1'b0;
                end else if (!st) begin
                    if (i == 0) begin
                        m[0].d = d;
                        m[0].v = v;
                    end else begin
                        m[i] = old[i-1];
                    end
                end
            end
            if (st) m_sc = (m_sc < CMAX) ? m_sc + 1 : CMAX;
            if (fl != '0) m_fc = (m_fc < CMAX) ? m_fc + 1 : CMAX;
        end
        exp_q.push_back(model_outputs());
        @(posedge clk);
    endtask

    // Asynchronous reset pulse between edges; outputs must clear before any edge.
    task automatic reset_pulse();
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_d_out", d_out, CLR);
        check("async_rst_v_out", v_out, 0);
        check("async_rst_occupancy", occupancy, 0);
        check("async_rst_stall_cycles", stall_cycles, 0);
        check("async_rst_flush_events", flush_events, 0);
        model_reset();
        reset = 1'b1;
    endtask

    // Monitor: after every rising edge compare the DUT against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("v_out", v_out, e.v);
                check("d_out", d_out, e.d);
                check("occupancy", occupancy, e.occ);
                check("stall_cycles", stall_cycles, e.sc);
                check("flush_events", flush_events, e.fc);
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b0;
        stall = 1'b0;
        flush = '0;
        d_in  = '0;
        v_in  = 1'b0;
        model_reset();

        // Held in reset with live upstream data: nothing may be captured.
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, '0, 32'hDEAD_BEEF, 1'b1);
        check("rst_hold_v_out", v_out, 0);

        // Latency: 1,2,3 emerge after the 3rd, 4th, 5th edges.
        drive(1, 0, '0, 32'h1, 1);
        drive(1, 0, '0, 32'h2, 1);
        drive(1, 0, '0, 32'h3, 1);
        drive(1, 0, '0, 32'h4, 1);
        drive(1, 0, '0, 32'h5, 0);

        // Stall with changing upstream data for four edges, then release.
        for (int i = 0; i < 4; i++) drive(1, 1, '0, 32'h100 + 32'(i), 1);
        drive(1, 0, '0, 32'h6, 1);

        // Load {s0=0x30, s1=0x20, s2=0x10}, then stall with middle flush.
        drive(1, 0, '0, 32'h10, 1);
        drive(1, 0, '0, 32'h20, 1);
        drive(1, 0, '0, 32'h30, 1);
        drive(1, 1, 3'b010, 32'h99, 1);

        // Flush stage 0 while advancing: old stage 0 still moves on.
        drive(1, 0, 3'b001, 32'h40, 1);
        drive(1, 0, '0, 32'h41, 1);
        drive(1, 0, 3'b100, 32'h42, 1);
        drive(1, 1, 3'b111, 32'h43, 1);
        drive(1, 0, '0, 32'h44, 0);

        // Saturate both counters, hold there, then clear with an async pulse.
        for (int i = 0; i < 20; i++) drive(1, 1, 3'b001, 32'h500 + 32'(i), 1);
        reset_pulse();
        drive(1, 0, '0, 32'h77, 1);

        // Randomised traffic with occasional asynchronous reset pulses.
        for (int i = 0; i < 400; i++) begin
            bit               st;
            logic [DEPTH-1:0] fl;
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 4) == 0) ? DEPTH'($urandom()) : '0;
            drive(1, st, fl, WIDTH'($urandom()), ($urandom_range(0, 3) != 0));
            if (i == 150 || i == 300) reset_pulse();
        end

        @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_register.md
Name: pipeline_stage_register

Overview:
Parametrised inter-stage pipeline register for the MIPS core. It generalises the fixed decode/execute register to any payload width and any depth of 1-4 back-to-back stages. Each stage carries a valid bit and can be flushed individually, and the whole chain freezes under stall. Saturating stall and flush counters feed the debug/perf path. Hazard unit drives stall/flush; the block sits between any two pipeline stages (decode->execute, execute->memory, ...).

Parameters:
WIDTH, 32, payload bits per stage
DEPTH, 1, number of register stages (legal 1..4); latency in cycles
CLEAR_VALUE, 0, payload value loaded on reset/flush (WIDTH bits)
CNT_W, 16, width of perf counters

Ports:
clk  input  1  rising-edge clock, sole clock
reset  input  1  asynchronous, active-low reset
stall  input  1  hold all stages this cycle
flush  input  DEPTH  per-stage clear; bit i clears stage i
d_in  input  WIDTH  payload from upstream stage
v_in  input  1  payload valid from upstream
d_out  output  WIDTH  payload of last stage (stage DEPTH-1)
v_out  output  1  valid of last stage
occupancy  output  3  count of stages with valid=1 (0..DEPTH)
stall_cycles  output  CNT_W  saturating count of stall cycles
flush_events  output  CNT_W  saturating count of cycles with flush!=0

Behaviour:
- Reset (reset=0, asynchronous assertion, synchronous release to next clk edge): every stage payload=CLEAR_VALUE, valid=0; d_out=CLEAR_VALUE, v_out=0, occupancy=0, stall_cycles=0, flush_events=0. Reset mid-operation discards all in-flight data immediately.
- Per-stage update at rising clk, priority flush > stall > advance:
  - flush[i]=1: stage i <= {CLEAR_VALUE, valid 0}, regardless of stall.
  - else stall=1: stage i holds payload and valid.
  - else advance: stage 0 <= {d_in, v_in}; stage i <= stage i-1 (i>=1).
- Stall+partial flush in the same cycle: flushed stages clear, unflushed stages hold. No data moves between stages.
- Flushing stage i-1 while advancing: stage i still receives the old pre-edge stage i-1 contents. The flush applies to stage i-1's new value only.
- Payload is captured even when v_in=0. Consumers must qualify with v_out.
- Latency: with no stall/flush, d_in at edge N appears on d_out after edge N+DEPTH-1. DEPTH=1 gives a one-cycle register, identical to the legacy decode/execute behaviour when flush is tied to clear.
- Outputs d_out and v_out are registered. occupancy is combinational popcount of the stage valid bits and is zero-extended.
- stall_cycles increments on every edge where stall=1 and reset is high, including stall with flush. flush_events increments on every edge where flush!=0. Both saturate at 2^CNT_W-1 and never wrap.
- DEPTH outside 1..4 is an elaboration error (generate-time check).
- X on stall/flush is a bench error; the RTL makes no guarantee for it.

Test Plan:
- Reset: hold reset=0 with d_in=0xDEADBEEF, v_in=1, clk toggling → d_out=0, v_out=0, occupancy=0, counters=0. Release reset, one edge → d_out=0xDEADBEEF (DEPTH=1).
- Latency, DEPTH=3, WIDTH=32: feed 0x1,0x2,0x3 with v_in=1 on consecutive edges → d_out=0x1 after 3rd edge, 0x2 after 4th, 0x3 after 5th. Occupancy reaches 3.
- Stall: DEPTH=2 full with {0xA,0xB}, stall=1 for 4 edges while d_in changes → d_out stays 0xA, occupancy=2, stall_cycles=4. Release → 0xB emerges next edge.
- Flush with stall: DEPTH=3 holding {s0=0x30,s1=0x20,s2=0x10}, stall=1, flush=3'b010, one edge → s1 cleared. d_out=0x10, occupancy=2, flush_events=1, stall_cycles=1.
- Flush while advancing: DEPTH=2 {s0=0x5,s1=0x4}, d_in=0x6, flush=2'b01, one edge → s1=0x5 (d_out=0x5, v_out=1), s0 cleared, occupancy=1.
- Saturation, CNT_W=3: stall=1 for 10 edges → stall_cycles=7, stays 7. Async reset pulse mid-clock → all counters 0 and v_out=0 immediately, before the next edge.
